motor_pwm_driver: RTL and testbench

- Output stage directly downstream of PID_controller. Converts the signed 32-bit controller result into a PWM waveform and a direction line for the motor H-bridge.
- Double-buffers each new command and applies it only at PWM period boundaries.
- Inserts a deadtime on every direction reversal.
- Emits a once-per-period tick that the top level wires to PID_controller.update_controller, so the control loop runs at the PWM rate.

---
 rtl/motor_ctrl_pkg.sv | 13 +
 rtl/pwm_mag_clamp.sv | 30 +++
 rtl/motor_pwm_driver.sv | 182 ++++++++++++++++++
 tb/tb_motor_pwm_driver.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_ctrl_pkg.sv
// Shared types and constants for the motor output stage.
package motor_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      DEADTIME = 2'd2
   } state_t;

   localparam int                  RESULT_W = 32;
   localparam logic [RESULT_W-1:0] MAG_SAT  = 32'h7FFF_FFFF;

endpackage

// File: rtl/pwm_mag_clamp.sv
// Turns a signed controller result into an unsigned duty no larger than the
// PWM period, flagging when the magnitude had to be limited.
module pwm_mag_clamp
   import motor_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
)(
   input  logic [RESULT_W-1:0] result,
   input  logic [CNT_W-1:0]    period,
   output logic [CNT_W-1:0]    duty,
   output logic                clamped
);

   logic [RESULT_W-1:0] mag;
   logic [RESULT_W-1:0] period_ext;

   // Absolute value (most negative input saturates), then clamp to the period
   always_comb begin
      mag = result;
      if (result == {1'b1, {(RESULT_W-1){1'b0}}})
         mag = MAG_SAT;
      else if (result[RESULT_W-1])
         mag = -result;
      period_ext              = '0;
      period_ext[CNT_W-1:0]   = period;
      clamped                 = (mag > period_ext);
      duty                    = clamped ? period : mag[CNT_W-1:0];
   end

endmodule

// File: rtl/motor_pwm_driver.sv
// PWM/direction output stage: double-buffers controller commands, applies
// them at period boundaries and inserts a deadtime on direction reversals.
module motor_pwm_driver
   import motor_ctrl_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int DT_W  = 8
)(
   input  logic                clock,
   input  logic                reset,
   input  logic                enable,
   input  logic [RESULT_W-1:0] result,
   input  logic                result_valid,
   input  logic [CNT_W-1:0]    pwm_period,
   input  logic [DT_W-1:0]     deadtime,
   output logic                pwm,
   output logic                dir,
   output logic                period_tick,
   output logic [CNT_W-1:0]    duty_applied,
   output logic                duty_clamped
);

   state_t              state_reg, state_next;
   logic [CNT_W-1:0]    counter_reg, counter_next;
   logic [RESULT_W-1:0] pending_reg, pending_next;
   logic                pending_valid_reg, pending_valid_next;
   logic [DT_W-1:0]     dt_cnt_reg, dt_cnt_next;
   logic                held_dir_reg, held_dir_next;
   logic [CNT_W-1:0]    held_duty_reg, held_duty_next;
   logic                held_clamped_reg, held_clamped_next;
   logic                pwm_reg, pwm_next;
   logic                dir_reg, dir_next;
   logic                tick_reg, tick_next;
   logic [CNT_W-1:0]    duty_reg, duty_next;
   logic                clamped_reg, clamped_next;

   logic                period_live, wrap, apply, cmd_dir, reversal;
   logic [CNT_W-1:0]    cmd_duty;
   logic                cmd_clamped;

   pwm_mag_clamp #(.CNT_W(CNT_W)) u_clamp (
      .result  (pending_reg),
      .period  (pwm_period),
      .duty    (cmd_duty),
      .clamped (cmd_clamped)
   );

   // Register all state; reset returns everything to zero / IDLE
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg         <= IDLE;
         counter_reg       <= '0;
         pending_reg       <= '0;
         pending_valid_reg <= 1'b0;
         dt_cnt_reg        <= '0;
         held_dir_reg      <= 1'b0;
         held_duty_reg     <= '0;
         held_clamped_reg  <= 1'b0;
         pwm_reg           <= 1'b0;
         dir_reg           <= 1'b0;
         tick_reg          <= 1'b0;
         duty_reg          <= '0;
         clamped_reg       <= 1'b0;
      end else begin
         state_reg         <= state_next;
         counter_reg       <= counter_next;
         pending_reg       <= pending_next;
         pending_valid_reg <= pending_valid_next;
         dt_cnt_reg        <= dt_cnt_next;
         held_dir_reg      <= held_dir_next;
         held_duty_reg     <= held_duty_next;
         held_clamped_reg  <= held_clamped_next;
         pwm_reg           <= pwm_next;
         dir_reg           <= dir_next;
         tick_reg          <= tick_next;
         duty_reg          <= duty_next;
         clamped_reg       <= clamped_next;
      end
   end

   // Next-state: period counter, command buffering, apply and deadtime sequencing
   always_comb begin
      state_next         = state_reg;
      counter_next       = counter_reg;
      pending_next       = pending_reg;
      pending_valid_next = pending_valid_reg;
      dt_cnt_next        = dt_cnt_reg;
      held_dir_next      = held_dir_reg;
      held_duty_next     = held_duty_reg;
      held_clamped_next  = held_clamped_reg;
      pwm_next           = 1'b0;
      dir_next           = dir_reg;
      duty_next          = duty_reg;
      clamped_next       = clamped_reg;

      period_live = (pwm_period != '0);
      // ">=" so a period shrunk below the running count wraps immediately
      wrap        = period_live && (counter_reg >= pwm_period - CNT_W'(1));
      apply       = wrap && pending_valid_reg;
      // A zero command carries no direction, so it keeps the current one
      cmd_dir     = (pending_reg == '0) ? dir_reg : pending_reg[RESULT_W-1];
      reversal    = (cmd_dir != dir_reg) && (deadtime != '0);

      if (result_valid)
         pending_next = result;

      case (state_reg)
         IDLE: begin
            counter_next       = '0;
            pending_valid_next = 1'b0;
            if (enable) begin
               state_next   = RUN;
               duty_next    = '0;
               clamped_next = 1'b0;
            end
         end
         RUN, DEADTIME: begin
            counter_next = (wrap || !period_live) ? '0 : counter_reg + CNT_W'(1);
            if (apply)
               pending_valid_next = 1'b0;
            // A strobe in the wrap cycle itself is kept for the next boundary
            if (result_valid)
               pending_valid_next = 1'b1;

            if (state_reg == RUN) begin
               pwm_next = period_live && (counter_reg < duty_reg);
               if (apply) begin
                  if (reversal) begin
                     state_next        = DEADTIME;
                     dt_cnt_next       = deadtime;
                     held_dir_next     = cmd_dir;
                     held_duty_next    = cmd_duty;
                     held_clamped_next = cmd_clamped;
                     duty_next         = '0;
                     clamped_next      = 1'b0;
                  end else begin
                     dir_next     = cmd_dir;
                     duty_next    = cmd_duty;
                     clamped_next = cmd_clamped;
                  end
               end
            end else begin
               // Newer command replaces the held one without restarting the count
               if (apply) begin
                  held_dir_next     = cmd_dir;
                  held_duty_next    = cmd_duty;
                  held_clamped_next = cmd_clamped;
               end
               if (dt_cnt_reg <= DT_W'(1)) begin
                  state_next   = RUN;
                  dt_cnt_next  = '0;
                  dir_next     = held_dir_next;
                  duty_next    = held_duty_next;
                  clamped_next = held_clamped_next;
               end else begin
                  dt_cnt_next = dt_cnt_reg - DT_W'(1);
               end
            end
         end
         default: state_next = IDLE;
      endcase

      if (!enable) begin
         state_next         = IDLE;
         counter_next       = '0;
         pwm_next           = 1'b0;
         pending_valid_next = 1'b0;
         dt_cnt_next        = '0;
         duty_next          = '0;
         clamped_next       = 1'b0;
      end

      tick_next = (state_next != IDLE) && period_live && (counter_next == '0);
   end

   assign pwm          = pwm_reg;
   assign dir          = dir_reg;
   assign period_tick  = tick_reg;
   assign duty_applied = duty_reg;
   assign duty_clamped = clamped_reg;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Self-checking bench for motor_pwm_driver against a behavioural model.
module tb_motor_pwm_driver;

   localparam int CNT_W = 16;
   localparam int DT_W  = 8;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             enable = 1'b0;
   logic [31:0]      result = '0;
   logic             result_valid = 1'b0;
   logic [CNT_W-1:0] pwm_period = '0;
   logic [DT_W-1:0]  deadtime = '0;
   logic             pwm, dir, period_tick, duty_clamped;
   logic [CNT_W-1:0] duty_applied;

   int checks   = 0;
   int failures = 0;

   // Behavioural model of the observable outputs
   int          m_cnt = 0;
   int          m_dt_left = 0;
   bit          m_run = 0, m_pv = 0, m_dir = 0, m_pwm = 0, m_tick = 0, m_clamp = 0;
   bit          m_hdir = 0, m_hclamp = 0;
   int          m_duty = 0, m_hduty = 0;
   logic [31:0] m_pend = '0;

   logic [19:0] dut_vec;
   assign dut_vec = {pwm, dir, period_tick, duty_clamped, duty_applied};

   motor_pwm_driver #(.CNT_W(CNT_W), .DT_W(DT_W)) dut (
      .clock        (clock),
      .reset        (reset),
      .enable       (enable),
      .result       (result),
      .result_valid (result_valid),
      .pwm_period   (pwm_period),
      .deadtime     (deadtime),
      .pwm          (pwm),
      .dir          (dir),
      .period_tick  (period_tick),
      .duty_applied (duty_applied),
      .duty_clamped (duty_clamped)
   );

   always #5 clock = ~clock;

   function automatic logic [19:0] model_vec();
      return {m_pwm, m_dir, m_tick, m_clamp, 16'(m_duty)};
   endfunction

   // Advance the model by one clock using the inputs present at the edge, then clock the DUT
   task automatic cycle();
      int     p, nduty;
      bit     boundary, entered, npwm, nclamp, ndir;
      longint v, mag;
      p = int'(pwm_period);
      if (reset) begin
         m_cnt = 0; m_dt_left = 0; m_run = 0; m_pv = 0; m_dir = 0; m_pwm = 0;
         m_tick = 0; m_clamp = 0; m_duty = 0; m_pend = '0;
         m_hdir = 0; m_hclamp = 0; m_hduty = 0;
      end else if (!enable) begin
         m_run = 0; m_dt_left = 0; m_cnt = 0; m_pwm = 0; m_tick = 0; m_pv = 0;
         m_duty = 0; m_clamp = 0;
         if (result_valid) m_pend = result;
      end else if (!m_run) begin
         m_run = 1; m_cnt = 0; m_duty = 0; m_clamp = 0; m_pwm = 0; m_pv = 0;
         if (result_valid) m_pend = result;
         m_tick = (p != 0);
      end else begin
         boundary = (p != 0) && (m_cnt >= p - 1);
         npwm     = (m_dt_left == 0) && (p != 0) && (m_cnt < m_duty);
         entered  = 0;
         if (boundary && m_pv) begin
            v   = longint'($signed(m_pend));
            mag = (v < 0) ? -v : v;
            if (mag > 2147483647) mag = 2147483647;
            nclamp = (mag > p);
            nduty  = nclamp ? p : int'(mag);
            ndir   = (m_pend == 0) ? m_dir : (v < 0);
            if (m_dt_left > 0) begin
               m_hdir = ndir; m_hduty = nduty; m_hclamp = nclamp;
            end else if (ndir != m_dir && deadtime != 0) begin
               m_hdir = ndir; m_hduty = nduty; m_hclamp = nclamp;
               m_dt_left = int'(deadtime); m_duty = 0; m_clamp = 0; entered = 1;
            end else begin
               m_dir = ndir; m_duty = nduty; m_clamp = nclamp;
            end
            m_pv = 0;
         end
         if (result_valid) begin m_pend = result; m_pv = 1; end
         if (m_dt_left > 0 && !entered) begin
            m_dt_left--;
            if (m_dt_left == 0) begin
               m_dir = m_hdir; m_duty = m_hduty; m_clamp = m_hclamp;
            end
         end
         m_cnt  = (boundary || p == 0) ? 0 : m_cnt + 1;
         m_tick = (p != 0) && (m_cnt == 0);
         m_pwm  = npwm;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b0; result_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cycle();
         checks++;
         if (dut_vec !== 20'h0) begin
            failures++;
            $display("FAIL reset: outputs=%h required=%h", dut_vec, 20'h0);
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_idle_ticks();
      int ticks = 0, highs = 0;
      enable = 1'b1; pwm_period = 16'd10; deadtime = 8'd0;
      for (int i = 0; i < 30; i++) begin
         cycle();
         ticks += int'(period_tick);
         highs += int'(pwm);
         checks++;
         if (dut_vec !== model_vec()) begin
            failures++;
            $display("FAIL idle_ticks: dut=%h expected=%h", dut_vec, model_vec());
         end
      end
      checks++;
      if (ticks !== 3 || highs !== 0) begin
         failures++;
         $display("FAIL tick_count: ticks=%0d highs=%0d required ticks=3 highs=0", ticks, highs);
      end
   endtask

   task automatic test_positive_duty();
      int highs = 0;
      for (int n = 0; n < 20 && m_cnt != 5; n++) cycle();
      result = 32'd4; result_valid = 1'b1;
      cycle();
      result_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         checks++;
         if (dut_vec !== model_vec()) begin
            failures++;
            $display("FAIL pos_duty: dut=%h expected=%h", dut_vec, model_vec());
         end
      end
      for (int i = 0; i < 10; i++) begin cycle(); highs += int'(pwm); end
      checks++;
      if (highs !== 4 || duty_applied !== 16'd4 || dir !== 1'b0 || duty_clamped !== 1'b0) begin
         failures++;
         $display("FAIL pos_duty_final: highs=%0d duty=%0d dir=%b clamp=%b required 4/4/0/0",
                  highs, duty_applied, dir, duty_clamped);
      end
   endtask

   task automatic test_reversal();
      int lows = 0, highs = 0;
      deadtime = 8'd3;
      for (int n = 0; n < 20 && m_cnt != 5; n++) cycle();
      result = -32'sd100000; result_valid = 1'b1;
      cycle();
      result_valid = 1'b0;
      for (int i = 0; i < 30; i++) begin
         cycle();
         lows += int'(!pwm);
         checks++;
         if (dut_vec !== model_vec()) begin
            failures++;
            $display("FAIL reversal: dut=%h expected=%h", dut_vec, model_vec());
         end
      end
      // 4 low slots from duty 4 at counter 6..9 (seen one cycle late) + 3 deadtime cycles
      checks++;
      if (lows !== 7) begin
         failures++;
         $display("FAIL deadtime_lows: got=%0d required=7", lows);
      end
      for (int i = 0; i < 10; i++) begin cycle(); highs += int'(pwm); end
      checks++;
      if (highs !== 10 || duty_applied !== 16'd10 || dir !== 1'b1 || duty_clamped !== 1'b1) begin
         failures++;
         $display("FAIL reversal_final: highs=%0d duty=%0d dir=%b clamp=%b required 10/10/1/1",
                  highs, duty_applied, dir, duty_clamped);
      end
   endtask

   task automatic test_min_int();
      pwm_period = 16'd7;
      cycle();
      result = 32'h8000_0000; result_valid = 1'b1;
      cycle();
      result_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         checks++;
         if (dut_vec !== model_vec()) begin
            failures++;
            $display("FAIL min_int: dut=%h expected=%h", dut_vec, model_vec());
         end
      end
      checks++;
      if (duty_applied !== 16'd7 || duty_clamped !== 1'b1 || dir !== 1'b1) begin
         failures++;
         $display("FAIL min_int_final: duty=%0d clamp=%b dir=%b required 7/1/1",
                  duty_applied, duty_clamped, dir);
      end
   endtask

   task automatic test_wrap_coincident();
      pwm_period = 16'd10; deadtime = 8'd0;
      for (int n = 0; n < 30 && m_cnt != 9; n++) cycle();
      result = 32'd3; result_valid = 1'b1;
      cycle();
      result_valid = 1'b0;
      checks++;
      if (duty_applied !== 16'd7 || dut_vec !== model_vec()) begin
         failures++;
         $display("FAIL wrap_strobe_first: duty=%0d required=7", duty_applied);
      end
      for (int n = 0; n < 30 && m_cnt != 9; n++) begin
         cycle();
         checks++;
         if (dut_vec !== model_vec()) begin
            failures++;
            $display("FAIL wrap_hold: dut=%h expected=%h", dut_vec, model_vec());
         end
      end
      checks++;
      if (duty_applied !== 16'd7) begin
         failures++;
         $display("FAIL wrap_old_persists: duty=%0d required=7", duty_applied);
      end
      cycle();
      checks++;
      if (duty_applied !== 16'd3 || dir !== 1'b0 || duty_clamped !== 1'b0) begin
         failures++;
         $display("FAIL wrap_applied: duty=%0d dir=%b clamp=%b required 3/0/0",
                  duty_applied, dir, duty_clamped);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         result_valid = ($urandom_range(5) == 0);
         case ($urandom_range(3))
            0:       result = $urandom();
            1:       result = 32'($urandom_range(40));
            2:       result = -32'($urandom_range(40));
            default: result = 32'h8000_0000;
         endcase
         if ($urandom_range(60) == 0) pwm_period = 16'($urandom_range(15));
         if ($urandom_range(60) == 0) deadtime = 8'($urandom_range(4));
         enable = ($urandom_range(150) != 0);
         reset  = ($urandom_range(400) == 0);
         cycle();
         checks++;
         if (dut_vec !== model_vec()) begin
            failures++;
            $display("FAIL random[%0d]: dut=%h expected=%h", i, dut_vec, model_vec());
         end
      end
      reset = 1'b0; enable = 1'b1; result_valid = 1'b0;
   endtask

   task automatic test_enable_drop_reset();
      int ticks = 0;
      pwm_period = 16'd10; deadtime = 8'd4; enable = 1'b1; result_valid = 1'b0;
      for (int n = 0; n < 60 && (m_dt_left != 0 || m_pv || !m_run); n++) cycle();
      result = m_dir ? 32'd5 : 32'hFFFF_FFFB; result_valid = 1'b1;
      cycle();
      result_valid = 1'b0;
      for (int n = 0; n < 30 && m_dt_left == 0; n++) cycle();
      checks++;
      if (dut_vec !== model_vec()) begin
         failures++;
         $display("FAIL in_deadtime: dut=%h expected=%h", dut_vec, model_vec());
      end
      enable = 1'b0;
      cycle();
      checks++;
      if (pwm !== 1'b0 || period_tick !== 1'b0 || dut_vec !== model_vec()) begin
         failures++;
         $display("FAIL enable_drop: dut=%h expected=%h", dut_vec, model_vec());
      end
      for (int i = 0; i < 12; i++) begin cycle(); ticks += int'(period_tick); end
      checks++;
      if (ticks !== 0) begin
         failures++;
         $display("FAIL idle_ticks_off: ticks=%0d required=0", ticks);
      end
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      checks++;
      if (dut_vec !== 20'h0) begin
         failures++;
         $display("FAIL final_reset: outputs=%h required=%h", dut_vec, 20'h0);
      end
   endtask

   initial begin
      test_reset();
      test_idle_ticks();
      test_positive_duty();
      test_reversal();
      test_min_int();
      test_wrap_coincident();
      test_random();
      test_enable_drop_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
